// File: rtl/pi_hold_decoder.sv
// ---------------------------------------------------------------------------
// pi_hold_decoder
//
// Receiving end of the priority-interrupt encoder. It takes an encoded grant
// level and turns it into an accumulating one-hot "hold" (in-progress) vector.
// It also tracks the highest-priority held level and retires levels on
// dismiss. A grant is accepted only when it strictly outranks every level
// already held. Level 0 is the highest priority.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   CROBAR       synchronous active-high reset, overrides every other input
//   grant_valid  grant strobe, one cycle per request
//   grant_level  encoded level to grant (0 = highest priority)
//   dismiss      retire the highest-priority held level
//   clear_all    drop every held level (a same-cycle accepted grant survives)
//   hold         one bit per level, set while that level is in progress
//   hold_any     OR of hold
//   hold_level   lowest-numbered set hold bit, 0 when nothing is held
//   ack          one-cycle pulse: the previous-cycle grant was accepted
//   nack         one-cycle pulse: the previous-cycle grant was refused
//   err_dismiss  sticky: a dismiss arrived while nothing was held
//
// Every output is a flop, so there are no combinational input-to-output paths.
// ---------------------------------------------------------------------------
module pi_hold_decoder #(
  parameter int N  = 8,
  parameter int LW = $clog2(N)
) (
  input  logic          clk,
  input  logic          CROBAR,
  input  logic          grant_valid,
  input  logic [0:LW-1] grant_level,
  input  logic          dismiss,
  input  logic          clear_all,
  output logic [0:N-1]  hold,
  output logic          hold_any,
  output logic [0:LW-1] hold_level,
  output logic          ack,
  output logic          nack,
  output logic          err_dismiss
);

  logic          accept;
  logic [0:N-1]  grant_mask;
  logic [0:N-1]  dismiss_mask;
  logic [0:N-1]  hold_next;
  logic [0:LW-1] level_next;

  // Acceptance and dismissal are both judged against the registered state.
  // hold_level is already registered, so the compare needs no priority
  // encoder on the critical path.
  assign accept = grant_valid & (~hold_any | (grant_level < hold_level));

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_mask   = '0;
    dismiss_mask = '0;
    if (accept) begin
      grant_mask[grant_level] = 1'b1;
    end
    if (dismiss && hold_any) begin
      dismiss_mask[hold_level] = 1'b1;
    end

    // The accepted bit can never be the dismissed bit, because the accept
    // compare is strict. So OR-ing the grant in after the clear is safe.
    if (clear_all) begin
      hold_next = grant_mask;
    end else begin
      hold_next = (hold & ~dismiss_mask) | grant_mask;
    end

    // Priority encode the next hold vector. Scanning downward lets the
    // lowest-numbered set bit make the last assignment, so it wins.
    level_next = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hold_next[i]) begin
        level_next = LW'(i);
      end
    end
  end

  // hold_any and hold_level come from the next-hold value, not from hold.
  // That keeps all three outputs coherent in the same cycle.
  // NOTE: sequential state uses non-blocking assignments only. Each flop then
  // samples pre-edge values no matter what order the statements run in.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      hold        <= '0;
      hold_any    <= 1'b0;
      hold_level  <= '0;
      ack         <= 1'b0;
      nack        <= 1'b0;
      err_dismiss <= 1'b0;
    end else begin
      hold        <= hold_next;
      hold_any    <= |hold_next;
      hold_level  <= level_next;
      ack         <= accept;
      nack        <= grant_valid & ~accept;
      if (dismiss && !hold_any) begin
        err_dismiss <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pi_hold_decoder.sv
// ---------------------------------------------------------------------------
// tb_pi_hold_decoder
//
// Directed steps taken from the block's intended behaviour, followed by a
// randomized run. Every step is checked against a set-of-held-levels
// reference model.
// ---------------------------------------------------------------------------
module tb_pi_hold_decoder;

  localparam int N  = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          CROBAR;
  logic          grant_valid;
  logic [0:LW-1] grant_level;
  logic          dismiss;
  logic          clear_all;
  logic [0:N-1]  hold;
  logic          hold_any;
  logic [0:LW-1] hold_level;
  logic          ack;
  logic          nack;
  logic          err_dismiss;

  pi_hold_decoder #(.N(N), .LW(LW)) dut (
    .clk         (clk),
    .CROBAR      (CROBAR),
    .grant_valid (grant_valid),
    .grant_level (grant_level),
    .dismiss     (dismiss),
    .clear_all   (clear_all),
    .hold        (hold),
    .hold_any    (hold_any),
    .hold_level  (hold_level),
    .ack         (ack),
    .nack        (nack),
    .err_dismiss (err_dismiss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the set of held levels, plus the pulse and error flags.
  bit m_held [N];
  bit m_ack, m_nack, m_err;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_held[i]);
    return c;
  endfunction

  function automatic int m_top();
    for (int i = 0; i < N; i++) if (m_held[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input bit rst, input bit gv, input int gl,
                            input bit dis, input bit clr);
    int  top;
    bit  busy;
    bit  acc;
    if (rst) begin
      foreach (m_held[i]) m_held[i] = 1'b0;
      m_ack = 0; m_nack = 0; m_err = 0;
      return;
    end
    busy = (m_count() != 0);
    top  = m_top();
    acc  = gv && (!busy || gl < top);
    if (dis && !busy) m_err = 1'b1;
    if (clr) begin
      foreach (m_held[i]) m_held[i] = 1'b0;
    end else if (dis && busy) begin
      m_held[top] = 1'b0;
    end
    if (acc) m_held[gl] = 1'b1;
    m_ack  = acc;
    m_nack = gv && !acc;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [0:N-1] exp_hold;
    for (int i = 0; i < N; i++) exp_hold[i] = m_held[i];
    check({tag, ".hold"},        32'(hold),        32'(exp_hold));
    check({tag, ".hold_any"},    32'(hold_any),    32'(m_count() != 0));
    check({tag, ".hold_level"},  32'(hold_level),  32'(m_top()));
    check({tag, ".ack"},         32'(ack),         32'(m_ack));
    check({tag, ".nack"},        32'(nack),        32'(m_nack));
    check({tag, ".err_dismiss"}, 32'(err_dismiss), 32'(m_err));
  endtask

  // Inputs are driven on the falling edge and outputs are sampled 1 ns after
  // the rising edge.
  task automatic step(input string tag, input bit rst, input bit gv,
                      input int gl, input bit dis, input bit clr);
    @(negedge clk);
    CROBAR      = rst;
    grant_valid = gv;
    grant_level = LW'(gl);
    dismiss     = dis;
    clear_all   = clr;
    @(posedge clk);
    model_step(rst, gv, gl, dis, clr);
    #1;
    check_model(tag);
  endtask

  initial begin
    CROBAR = 1'b1; grant_valid = 1'b0; grant_level = '0;
    dismiss = 1'b0; clear_all = 1'b0;

    // Reset, then idle.
    step("rst0", 1, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    check("idle.hold_lit", 32'(hold), 32'h0);

    // Nesting: grant 5, grant 2, grant 2 again.
    step("nest5", 0, 1, 5, 0, 0);
    check("nest5.hold_lit", 32'(hold), 32'b00000100);
    check("nest5.ack_lit",  32'(ack), 32'd1);
    step("nest2", 0, 1, 2, 0, 0);
    check("nest2.hold_lit", 32'(hold), 32'b00100100);
    check("nest2.lvl_lit",  32'(hold_level), 32'd2);
    step("nest2b", 0, 1, 2, 0, 0);
    check("nest2b.nack_lit", 32'(nack), 32'd1);

    // Dismiss order, then the sticky error on an empty dismiss.
    step("dis1", 0, 0, 0, 1, 0);
    check("dis1.hold_lit", 32'(hold), 32'b00000100);
    step("dis2", 0, 0, 0, 1, 0);
    check("dis2.any_lit", 32'(hold_any), 32'd0);
    step("dis3", 0, 0, 0, 1, 0);
    check("dis3.err_lit", 32'(err_dismiss), 32'd1);
    step("dis3b", 0, 0, 0, 0, 0);
    check("dis3b.err_lit", 32'(err_dismiss), 32'd1);

    // Refusal of a lower-priority grant.
    step("rst2", 1, 0, 0, 0, 0);
    step("ref3", 0, 1, 3, 0, 0);
    step("ref6", 0, 1, 6, 0, 0);
    check("ref6.lvl_lit", 32'(hold_level), 32'd3);
    step("ref7", 0, 1, 7, 0, 0);   // lowest priority, boundary code
    step("ref0", 0, 1, 0, 0, 0);   // highest priority, boundary code

    // Grant and dismiss in the same cycle.
    step("rst3", 1, 0, 0, 0, 0);
    step("sim5", 0, 1, 5, 0, 0);
    step("sim1", 0, 1, 1, 1, 0);
    check("sim1.hold_lit", 32'(hold), 32'b01000000);
    check("sim1.lvl_lit",  32'(hold_level), 32'd1);

    // clear_all with a grant: refused the first time, accepted the second.
    step("clr4a", 0, 1, 4, 0, 1);
    check("clr4a.hold_lit", 32'(hold), 32'h0);
    step("clr4b", 0, 1, 4, 0, 1);
    check("clr4b.hold_lit", 32'(hold), 32'b00001000);
    // A dismiss is ignored under clear_all, but the accepted grant survives.
    step("clr_dis", 0, 1, 2, 1, 1);

    // Reset in the cycle after a grant suppresses the pending ack.
    step("pre_rst", 0, 1, 0, 0, 0);
    step("mid_rst", 1, 0, 0, 0, 0);
    check("mid_rst.ack_lit", 32'(ack), 32'd0);

    // Randomized run against the model.
    for (int k = 0; k < 400; k++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) != 0),
           int'($urandom_range(0, N - 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
